// File: rtl/sound_latch_bridge.sv
// Sound command latch between the 68000 and the Z80: holds the command byte, raises the
// Z80 interrupt while it is pending, reports status to the 68k and generates 68k DTACK.
//
// state    | meaning
// ST_IDLE  | no 68k access in progress, waiting for a decoded strobe
// ST_WAIT  | counting wait cycles before acknowledging the access
// ST_ACK   | DTACK asserted until the 68k releases its address strobe

module sound_latch_bridge #(
  parameter int DTACK_WAIT = 2,
  parameter int STATUS_BIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_as_n,
  input  logic        m68k_lds_n,
  input  logic        m68k_any_cs,
  input  logic        m68k_latch_cs,
  input  logic        m68k_sound_cs,
  input  logic [15:0] m68k_din,
  output logic [15:0] m68k_dout,
  output logic        m68k_dtack_n,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  output logic [7:0]  z80_dout,
  output logic        z80_int_n,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(DTACK_WAIT);

  logic        wr_qual, rd_qual, clr_qual, acc_qual;
  logic        wr_low_q, rd_low_q, clr_low_q, acc_low_q;
  logic        wr_ev, rd_ev, clr_ev, acc_ev;

  logic [7:0]  latch_q, latch_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        int_n_q, int_n_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] status_w;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        unused_ok;

  assign wr_qual  = m68k_latch_cs & ~m68k_lds_n;
  assign rd_qual  = z80_latch_cs & ~z80_rd_n;
  assign clr_qual = z80_latch_cs & ~z80_wr_n;
  assign acc_qual = m68k_any_cs & ~m68k_as_n;

  // The *_low_q registers record "qualifier was low last clk". They reset to 0, so a strobe
  // still held when reset releases must first be seen low before it can fire an event.
  assign wr_ev  = wr_qual & wr_low_q;
  assign rd_ev  = rd_qual & rd_low_q;
  assign clr_ev = clr_qual & clr_low_q;
  assign acc_ev = acc_qual & acc_low_q;

  // The Z80 read is observable only on the bus; it has no effect on latch state.
  assign unused_ok = ^{m68k_din[15:8], rd_ev};

  always_comb begin
    status_w             = '0;
    status_w[15:8]       = latch_q;
    status_w[STATUS_BIT] = pending_q;
  end

  always_comb begin
    latch_d   = latch_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    dout_d    = dout_q;
    int_n_d   = ~pending_q;
    if (wr_ev) begin
      latch_d   = m68k_din[7:0];
      pending_d = 1'b1;
      // A clear in the same clk consumes the old command, so it is not an overrun.
      if (pending_q && !clr_ev) overrun_d = 1'b1;
    end else if (clr_ev) begin
      pending_d = 1'b0;
    end
    if (m68k_sound_cs) dout_d = status_w;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_ev) begin
          cnt_d   = WAIT_INIT;
          state_d = (DTACK_WAIT == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (m68k_as_n) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (m68k_as_n) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_low_q  <= 1'b0;
      rd_low_q  <= 1'b0;
      clr_low_q <= 1'b0;
      acc_low_q <= 1'b0;
      latch_q   <= 8'h00;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      int_n_q   <= 1'b1;
      dout_q    <= 16'h0000;
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
    end else begin
      wr_low_q  <= ~wr_qual;
      rd_low_q  <= ~rd_qual;
      clr_low_q <= ~clr_qual;
      acc_low_q <= ~acc_qual;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      int_n_q   <= int_n_d;
      dout_q    <= dout_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  // DTACK drops combinationally with the address strobe so it releases in the same clk.
  assign m68k_dtack_n = ~((state_q == ST_ACK) & ~m68k_as_n);
  assign m68k_dout    = dout_q;
  assign z80_dout     = latch_q;
  assign z80_int_n    = int_n_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Bench for sound_latch_bridge: two instances (DTACK_WAIT = 2 and 0) share one stimulus;
// table vectors, hand-written corner sequences and a randomized run against a command model.

module tb_sound_latch_bridge;

  localparam int OP_WR  = 0;
  localparam int OP_RD  = 1;
  localparam int OP_CLR = 2;
  localparam int OP_ST  = 3;

  typedef struct {
    int          op;
    logic [7:0]  data;
    logic [7:0]  exp_latch;
    logic        exp_int_n;
    logic        exp_ovr;
    logic [15:0] exp_dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m68k_as_n, m68k_lds_n, m68k_any_cs, m68k_latch_cs, m68k_sound_cs;
  logic [15:0] m68k_din;
  logic        z80_latch_cs, z80_rd_n, z80_wr_n;
  logic [15:0] dout0, dout1;
  logic        dtack0, dtack1, int0, int1, ovr0, ovr1;
  logic [7:0]  zdout0, zdout1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sound_latch_bridge #(.DTACK_WAIT(2), .STATUS_BIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .m68k_as_n(m68k_as_n), .m68k_lds_n(m68k_lds_n), .m68k_any_cs(m68k_any_cs),
    .m68k_latch_cs(m68k_latch_cs), .m68k_sound_cs(m68k_sound_cs), .m68k_din(m68k_din),
    .m68k_dout(dout0), .m68k_dtack_n(dtack0),
    .z80_latch_cs(z80_latch_cs), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_dout(zdout0), .z80_int_n(int0), .overrun(ovr0)
  );

  sound_latch_bridge #(.DTACK_WAIT(0), .STATUS_BIT(0)) dut1 (
    .clk(clk), .reset(reset),
    .m68k_as_n(m68k_as_n), .m68k_lds_n(m68k_lds_n), .m68k_any_cs(m68k_any_cs),
    .m68k_latch_cs(m68k_latch_cs), .m68k_sound_cs(m68k_sound_cs), .m68k_din(m68k_din),
    .m68k_dout(dout1), .m68k_dtack_n(dtack1),
    .z80_latch_cs(z80_latch_cs), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_dout(zdout1), .z80_int_n(int1), .overrun(ovr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    m68k_as_n     = 1'b1;
    m68k_lds_n    = 1'b1;
    m68k_any_cs   = 1'b0;
    m68k_latch_cs = 1'b0;
    m68k_sound_cs = 1'b0;
    z80_latch_cs  = 1'b0;
    z80_rd_n      = 1'b1;
    z80_wr_n      = 1'b1;
  endtask

  task automatic reset_dut();
    idle_bus();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // 68k bus cycle: write to the latch or read of the status, with DTACK latency checks.
  task automatic m68k_access(input logic is_write, input logic is_status,
                             input logic [7:0] d, input int extra);
    int l0, l1;
    l0 = -1;
    l1 = -1;
    m68k_din      = {8'hC3, d};
    m68k_as_n     = 1'b0;
    m68k_lds_n    = 1'b0;
    m68k_any_cs   = 1'b1;
    m68k_latch_cs = is_write;
    m68k_sound_cs = is_status;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (l0 < 0 && dtack0 === 1'b0) l0 = i;
      if (l1 < 0 && dtack1 === 1'b0) l1 = i;
    end
    chk("dtack_latency_w2", l0, 3);
    chk("dtack_latency_w0", l1, 1);
    repeat (extra) tick();
    m68k_as_n = 1'b1;
    #1;
    chk("dtack_release_w2", {31'd0, dtack0}, 1);
    chk("dtack_release_w0", {31'd0, dtack1}, 1);
    idle_bus();
    tick();
  endtask

  task automatic z80_access(input logic is_wr, input int hold);
    z80_latch_cs = 1'b1;
    if (is_wr) z80_wr_n = 1'b0;
    else       z80_rd_n = 1'b0;
    repeat (hold) tick();
    idle_bus();
    tick();
  endtask

  vec_t        tbl [8];
  logic [7:0]  m_latch;
  logic        m_pend, m_ovr;
  logic [15:0] m_status;
  int          lows;

  initial begin
    tbl[0] = '{OP_WR,  8'h11, 8'h11, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{OP_WR,  8'h22, 8'h22, 1'b0, 1'b1, 16'h0000};
    tbl[2] = '{OP_RD,  8'h00, 8'h22, 1'b0, 1'b1, 16'h0000};
    tbl[3] = '{OP_ST,  8'h00, 8'h22, 1'b0, 1'b1, 16'h2201};
    tbl[4] = '{OP_CLR, 8'h00, 8'h22, 1'b1, 1'b1, 16'h0000};
    tbl[5] = '{OP_ST,  8'h00, 8'h22, 1'b1, 1'b1, 16'h2200};
    tbl[6] = '{OP_WR,  8'h44, 8'h44, 1'b0, 1'b1, 16'h0000};
    tbl[7] = '{OP_ST,  8'h00, 8'h44, 1'b0, 1'b1, 16'h4401};

    m68k_din = 16'h0000;
    idle_bus();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_m68k_dout", dout0, 16'h0000);
    chk("reset_dtack_n", {31'd0, dtack0}, 1);
    chk("reset_int_n", {31'd0, int0}, 1);
    chk("reset_z80_dout", zdout0, 8'h00);
    chk("reset_overrun", {31'd0, ovr0}, 0);

    // 68k write of 00A5 held for 6 clks
    m68k_din      = 16'h00A5;
    m68k_as_n     = 1'b0;
    m68k_any_cs   = 1'b1;
    m68k_latch_cs = 1'b1;
    m68k_lds_n    = 1'b0;
    tick();
    chk("wr_latch_after_1", zdout0, 8'hA5);
    chk("wr_int_n_after_1", {31'd0, int0}, 1);
    tick();
    chk("wr_int_n_after_2", {31'd0, int0}, 0);
    repeat (4) tick();
    chk("wr_single_event", {31'd0, ovr0}, 0);
    idle_bus();
    tick();

    // Z80 read keeps the command pending, then the Z80 write clears it
    z80_access(1'b0, 3);
    chk("rd_keeps_pending", {31'd0, int0}, 0);
    chk("rd_z80_dout", zdout0, 8'hA5);
    z80_latch_cs = 1'b1;
    z80_wr_n     = 1'b0;
    tick();
    chk("clr_int_n_same_clk", {31'd0, int0}, 0);
    tick();
    chk("clr_int_n_next_clk", {31'd0, int0}, 1);
    chk("clr_latch_kept", zdout0, 8'hA5);
    idle_bus();
    tick();

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_WR:   m68k_access(1'b1, 1'b0, tbl[i].data, 0);
        OP_RD:   z80_access(1'b0, 2);
        OP_CLR:  z80_access(1'b1, 2);
        default: m68k_access(1'b0, 1'b1, 8'h00, 1);
      endcase
      tick();
      chk("tbl_z80_dout", zdout0, tbl[i].exp_latch);
      chk("tbl_int_n", {31'd0, int0}, {31'd0, tbl[i].exp_int_n});
      chk("tbl_overrun", {31'd0, ovr0}, {31'd0, tbl[i].exp_ovr});
      if (tbl[i].op == OP_ST) chk("tbl_status", dout0, tbl[i].exp_dout);
    end
    repeat (3) tick();
    chk("overrun_sticky", {31'd0, ovr0}, 1);

    reset_dut();
    chk("overrun_reset", {31'd0, ovr0}, 0);

    // Simultaneous 68k write and Z80 clear while pending
    m68k_access(1'b1, 1'b0, 8'h55, 0);
    m68k_din      = 16'h0033;
    m68k_as_n     = 1'b0;
    m68k_any_cs   = 1'b1;
    m68k_latch_cs = 1'b1;
    m68k_lds_n    = 1'b0;
    z80_latch_cs  = 1'b1;
    z80_wr_n      = 1'b0;
    tick();
    chk("coll_latch", zdout0, 8'h33);
    tick();
    tick();
    chk("coll_pending", {31'd0, int0}, 0);
    chk("coll_no_overrun", {31'd0, ovr0}, 0);
    idle_bus();
    tick();
    m68k_access(1'b0, 1'b1, 8'h00, 0);
    chk("coll_status", dout0, 16'h3301);

    // Address strobe released during WAIT: no DTACK from the DTACK_WAIT=2 instance
    m68k_as_n   = 1'b0;
    m68k_any_cs = 1'b1;
    lows = 0;
    tick();
    if (dtack0 !== 1'b1) lows++;
    idle_bus();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (dtack0 !== 1'b1) lows++;
      tick();
    end
    chk("abort_no_dtack", lows, 0);

    // Reset while acknowledging with strobes still held
    m68k_din      = 16'h0077;
    m68k_as_n     = 1'b0;
    m68k_any_cs   = 1'b1;
    m68k_latch_cs = 1'b1;
    m68k_lds_n    = 1'b0;
    repeat (4) tick();
    chk("pre_reset_ack", {31'd0, dtack0}, 0);
    reset = 1'b1;
    tick();
    chk("mid_reset_dtack_w2", {31'd0, dtack0}, 1);
    chk("mid_reset_dtack_w0", {31'd0, dtack1}, 1);
    chk("mid_reset_int_n", {31'd0, int0}, 1);
    chk("mid_reset_z80_dout", zdout0, 8'h00);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dtack0 !== 1'b1 || dtack1 !== 1'b1 || int0 !== 1'b1) lows++;
    end
    chk("held_strobe_no_event", lows, 0);
    chk("held_strobe_latch", zdout0, 8'h00);
    idle_bus();
    tick();

    // Randomized command traffic against a transaction-level model
    reset_dut();
    m_latch = 8'h00;
    m_pend  = 1'b0;
    m_ovr   = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [7:0] d;
      op = int'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      case (op)
        OP_WR: begin
          m68k_access(1'b1, 1'b0, d, int'($urandom_range(0, 2)));
          if (m_pend) m_ovr = 1'b1;
          m_latch = d;
          m_pend  = 1'b1;
        end
        OP_RD: z80_access(1'b0, int'($urandom_range(1, 4)));
        OP_CLR: begin
          z80_access(1'b1, int'($urandom_range(1, 4)));
          m_pend = 1'b0;
        end
        default: begin
          m68k_access(1'b0, 1'b1, 8'h00, int'($urandom_range(0, 2)));
          m_status = {m_latch, 7'd0, m_pend};
          chk("rnd_status", dout0, m_status);
        end
      endcase
      tick();
      chk("rnd_z80_dout", zdout0, m_latch);
      chk("rnd_int_n", {31'd0, int0}, {31'd0, ~m_pend});
      chk("rnd_overrun", {31'd0, ovr0}, {31'd0, m_ovr});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_latch_bridge.md
Name: sound_latch_bridge

Overview:
- Responder side of the 68k-to-Z80 sound command path; it acts on the chip selects produced by the address decoder.
- Holds the 8-bit sound command written by the 68000 and raises the Z80 interrupt while a command is pending.
- Lets the Z80 read the command and clear it, and returns the pending status to the 68000.
- Generates 68000 DTACK for every decoded 68k access, with a programmable number of wait cycles.

Parameters:
- DTACK_WAIT, 2: clk cycles from access detection to DTACK assertion (range 0..15).
- STATUS_BIT, 0: bit position of the pending flag in the 68k status word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- m68k_as_n  in  1  68000 address strobe.
- m68k_lds_n  in  1  68000 lower data strobe.
- m68k_any_cs  in  1  OR of every decoded 68k chip select.
- m68k_latch_cs  in  1  68k write to the command latch (odd byte).
- m68k_sound_cs  in  1  68k read of the sound status.
- m68k_din  in  16  68k write data; bits [7:0] are used.
- m68k_dout  out  16  status word for the 68k read.
- m68k_dtack_n  out  1  data acknowledge to the 68000.
- z80_latch_cs  in  1  Z80 memory access to the latch location.
- z80_rd_n  in  1  Z80 read strobe.
- z80_wr_n  in  1  Z80 write strobe.
- z80_dout  out  8  latch contents to the Z80 data bus.
- z80_int_n  out  1  Z80 maskable interrupt, active-low.
- overrun  out  1  sticky flag: a 68k write landed while a command was still pending.

Behaviour:
- Reset values:
  - latch = 8'h00, pending = 0, overrun = 0.
  - m68k_dout = 16'h0000, m68k_dtack_n = 1, z80_int_n = 1.
  - FSM in IDLE; wait counter = 0; all edge-detect registers = 0.
- Event detection: each event is a rising edge of a registered qualifier, so it fires exactly once per bus cycle however long the strobe is held.
  - 68k write event: m68k_latch_cs & !m68k_lds_n.
  - Z80 read event: z80_latch_cs & !z80_rd_n.
  - Z80 clear event: z80_latch_cs & !z80_wr_n.
- 68k write event:
  - latch <= m68k_din[7:0]; pending <= 1 on the next clk.
  - If pending was already 1, overrun <= 1.
- Z80 clear event: pending <= 0; latch contents are kept.
- Z80 read event: has no side effects; the read does not clear pending.
- z80_dout = latch, registered, so it is valid one clk after any write.
- z80_int_n = !pending, registered. It falls one clk after pending sets and rises one clk after the clear.
- Simultaneous 68k write event and Z80 clear event in the same clk: the write wins. pending = 1, latch takes the new data, overrun is not set.
- m68k_dout is loaded whenever m68k_sound_cs is high:
  - bit STATUS_BIT = pending; bits [15:8] = latch; all other bits = 0.
  - The value is held while the chip select is low.
- DTACK FSM:
  - IDLE: on a rising edge of (m68k_any_cs & !m68k_as_n), load the counter with DTACK_WAIT. Go to WAIT, or directly to ACK when DTACK_WAIT = 0.
  - WAIT: decrement the counter; go to ACK when it reaches 1. If m68k_as_n rises during WAIT (aborted cycle), return to IDLE without asserting DTACK.
  - ACK: m68k_dtack_n = 0. Hold until m68k_as_n = 1, then deassert DTACK in the same clk and return to IDLE.
  - Latency: m68k_dtack_n falls DTACK_WAIT+1 clks after the clk in which the qualifier is first seen high.
- overrun is cleared only by reset.
- Reset asserted mid-access:
  - All state returns to reset values on the next clk and m68k_dtack_n goes high.
  - A strobe still held when reset releases produces no event until it has been seen low for at least one clk.

Test Plan:
- 68k write: reset, then a 68k write of 16'h00A5 with latch_cs and lds_n = 0 held for 6 clks.
  - latch = 8'hA5 and pending = 1 after 1 clk; z80_int_n = 0 after 2 clks.
  - Exactly one event fires; overrun stays 0.
- Z80 read then clear:
  - A Z80 read leaves pending = 1 and z80_dout = 8'hA5.
  - A following Z80 write clears pending; z80_int_n = 1 one clk later; latch is still 8'hA5.
- Overrun: 68k writes 8'h11 then 8'h22 with no clear in between -> latch = 8'h22, overrun = 1 and stays 1 until reset.
- Collision and status read: pending = 1, then a 68k write of 8'h33 and a Z80 clear fire in the same clk -> pending = 1, latch = 8'h33, overrun = 0. A subsequent 68k status read gives m68k_dout = 16'h3301.
- DTACK timing: run with DTACK_WAIT = 2 and again with DTACK_WAIT = 0.
  - m68k_dtack_n falls 3 clks (DTACK_WAIT = 2) or 1 clk (DTACK_WAIT = 0) after the access is detected.
  - m68k_dtack_n rises in the clk m68k_as_n goes high.
  - as_n rising during WAIT -> DTACK is never asserted.
- Reset mid-access: assert reset while in ACK with as_n still low -> m68k_dtack_n = 1, pending = 0, z80_int_n = 1. With the strobes still held after reset releases, no new event fires.
